// File: rtl/icache_axi_refill_if.sv
`default_nettype none
// ============================================================================
//  Module   : icache_axi_refill_if
//  Purpose  : AXI4 read-address and read-data channel bundle used by the
//             ICache refill responder (master) and the memory/crossbar (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface icache_axi_refill_if #(
   parameter int AXI_ID_W = 4
);
   // AR channel
   logic [AXI_ID_W-1:0] arid;
   logic [31:0]         araddr;
   logic [7:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic [1:0]          arlock;
   logic [3:0]          arcache;
   logic [2:0]          arprot;
   logic                arvalid;
   logic                arready;
   // R channel
   logic [AXI_ID_W-1:0] rid;
   logic [31:0]         rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
      output arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
      input  arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface
`default_nettype wire

// File: rtl/icache_axi_refill.sv
`default_nettype none
// ============================================================================
//  Module   : icache_axi_refill
//  Purpose  : Memory-side responder for ICache line refills. One request
//             becomes one AXI4 read burst of LINE_WORDS beats; the beats are
//             assembled into a full line returned with a one-cycle rvalid.
//  Options  : CRITICAL_WORD_FIRST_EN - WRAP burst starting at the miss word.
//  Revision : 1.0  initial release
// ============================================================================
module icache_axi_refill #(
   parameter int LINE_WORDS = 8,
   parameter int AXI_ID_W   = 4,
   parameter int ARID_VAL   = 0
) (
   input  wire logic                    clk,
   input  wire logic                    rst,
   input  wire logic                    mem_inst_ren_i,
   input  wire logic [31:0]             mem_inst_araddr_i,
   output logic                         mem_inst_rvalid_o,
   output logic [32*LINE_WORDS-1:0]     mem_inst_rdata_o,
   output logic                         refill_err_o,
   output logic                         busy_o,
   icache_axi_refill_if.master          axi
);

   localparam int BEAT_W  = $clog2(LINE_WORDS);
   localparam int OFF_W   = BEAT_W + 2;

   localparam logic [AXI_ID_W-1:0] c_arid = AXI_ID_W'(ARID_VAL);
   localparam logic [BEAT_W-1:0]   c_last = BEAT_W'(LINE_WORDS - 1);
   localparam logic [BEAT_W-1:0]   c_one  = BEAT_W'(1);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_ar   = 2'd1;
   localparam logic [1:0] c_r    = 2'd2;
   localparam logic [1:0] c_done = 2'd3;

   logic [1:0]              r_state;
   logic [1:0]              w_next;
   logic [31:0]             r_araddr;
   logic [BEAT_W-1:0]       r_cnt;
   logic                    r_err;
   logic [32*LINE_WORDS-1:0] r_line;
   logic [BEAT_W-1:0]       w_idx;
   logic [31:0]             w_req_addr;
   logic                    w_beat;
   logic                    w_beat_err;
   logic                    w_unused;

   // A beat counts only when it carries our ID; foreign IDs are drained.
   assign w_beat     = axi.rvalid && (axi.rid == c_arid);
   assign w_beat_err = (axi.rresp != 2'b00) || (axi.rlast != (r_cnt == c_last));

`ifdef CRITICAL_WORD_FIRST_EN
   logic [BEAT_W-1:0] r_start;

   // Word-aligned start; beats wrap around the line from the missed word.
   assign w_req_addr = {mem_inst_araddr_i[31:2], 2'b00};
   assign w_idx      = r_start + r_cnt;
   assign w_unused   = ^mem_inst_araddr_i[1:0];
   assign axi.arburst = 2'b10;

   // Remember the critical word so beat k lands at (start + k) mod LINE_WORDS.
   always_ff @(posedge clk) begin
      if (rst)
         r_start <= '0;
      else if (r_state == c_idle && mem_inst_ren_i)
         r_start <= mem_inst_araddr_i[OFF_W-1:2];
   end
`else
   // Line-aligned INCR burst; beat k lands at word k.
   assign w_req_addr = {mem_inst_araddr_i[31:OFF_W], {OFF_W{1'b0}}};
   assign w_idx      = r_cnt;
   assign w_unused   = ^mem_inst_araddr_i[OFF_W-1:0];
   assign axi.arburst = 2'b01;
`endif

   // Fixed AR attributes: full-line burst of 32-bit beats, normal access.
   assign axi.arid    = c_arid;
   assign axi.araddr  = r_araddr;
   assign axi.arlen   = 8'(LINE_WORDS - 1);
   assign axi.arsize  = 3'b010;
   assign axi.arlock  = 2'b00;
   assign axi.arcache = 4'b0000;
   assign axi.arprot  = 3'b000;

   assign mem_inst_rdata_o = r_line;

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= c_idle;
      else
         r_state <= w_next;
   end

   // Next-state: the beat counter alone decides when the burst is complete.
   always_comb begin
      w_next = r_state;
      case (r_state)
         c_idle:  if (mem_inst_ren_i) w_next = c_ar;
         c_ar:    if (axi.arready) w_next = c_r;
         c_r:     if (w_beat && (r_cnt == c_last)) w_next = c_done;
         c_done:  w_next = c_idle;
         default: w_next = c_idle;
      endcase
   end

   // Outputs decoded from state; DONE is the single-cycle line-ready pulse.
   always_comb begin
      axi.arvalid       = (r_state == c_ar);
      axi.rready        = (r_state == c_r);
      mem_inst_rvalid_o = (r_state == c_done);
      refill_err_o      = (r_state == c_done) && r_err;
      busy_o            = (r_state != c_idle);
   end

   // Request latch, beat assembly and error accumulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_araddr <= '0;
         r_cnt    <= '0;
         r_err    <= 1'b0;
         r_line   <= '0;
      end else begin
         case (r_state)
            c_idle: begin
               if (mem_inst_ren_i) begin
                  r_araddr <= w_req_addr;
                  r_cnt    <= '0;
                  r_err    <= 1'b0;
               end
            end
            c_r: begin
               if (w_beat) begin
                  r_line[{w_idx, 5'd0} +: 32] <= axi.rdata;
                  r_cnt <= r_cnt + c_one;
                  if (w_beat_err)
                     r_err <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire
